// File: rtl/shr_out_stage.sv
// shr_out_stage: registered elastic stage after the right-shifter; adds zero/shift_out_all flags.
// Latency: 1 cycle from input accept to out_valid when empty; 1 entry/cycle sustained throughput.
// Backpressure: 2-entry skid (main + skid); in_ready is registered and drops only when both are full.
// Optional: define SHR_OUT_STATS_EN to add a 16-bit wrapping output-transfer counter (xfer_count).
module shr_out_stage #(
  parameter int DATAWIDTH = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] d_in,
  input  logic [DATAWIDTH-1:0] sh_amt_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] d_out,
  output logic                 zero,
  output logic                 shift_out_all
`ifdef SHR_OUT_STATS_EN
  ,
  output logic [15:0]          xfer_count
`endif
);

  // Compare width wide enough to hold both the shift amount and DATAWIDTH itself,
  // so the threshold test never truncates either operand.
  localparam int CW = (DATAWIDTH > 32) ? DATAWIDTH : 32;
  localparam logic [CW-1:0] SHIFT_LIMIT = CW'(DATAWIDTH);

  typedef struct packed {
    logic [DATAWIDTH-1:0] d;
    logic                 zero;
    logic                 soa;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t  state_q;
  entry_t  main_q;
  entry_t  skid_q;
  entry_t  in_ent_d;
  logic    out_valid_q;
  logic    in_ready_q;
  logic    in_xfer;
  logic    out_xfer;
  logic [CW-1:0] amt_ext;

  // Build the entry to capture: result plus both flags derived at capture time.
  always_comb begin
    amt_ext       = CW'(sh_amt_in);
    in_ent_d.d    = d_in;
    in_ent_d.zero = (d_in == '0);
    in_ent_d.soa  = (amt_ext >= SHIFT_LIMIT);
  end

  // Handshake qualification; in_ready/out_valid are the registered copies so neither side sees a comb path.
  always_comb begin
    in_xfer  = in_valid && in_ready_q;
    out_xfer = out_valid_q && out_ready;
  end

  // Skid-buffer FSM: state, storage and registered handshake outputs updated together.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q      <= in_ent_d;
            state_q     <= ST_HALF;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        ST_HALF: begin
          if (in_xfer && !out_xfer) begin
            // Consumer stalled: park the new entry behind main and close the input.
            skid_q      <= in_ent_d;
            state_q     <= ST_FULL;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
          end else if (out_xfer && !in_xfer) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end else if (in_xfer && out_xfer) begin
            main_q      <= in_ent_d;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer) begin
            main_q      <= skid_q;
            state_q     <= ST_HALF;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign d_out         = main_q.d;
  assign zero          = main_q.zero;
  assign shift_out_all = main_q.soa;

`ifdef SHR_OUT_STATS_EN
  logic [15:0] xfer_count_q;

  // Count accepted outputs; natural 16-bit wrap.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      xfer_count_q <= '0;
    end else if (out_xfer) begin
      xfer_count_q <= xfer_count_q + 16'd1;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_shr_out_stage.sv
// Bench for shr_out_stage at DATAWIDTH = 8: directed sequences, flag vector table,
// random stream against a scoreboard queue, mid-operation reset and optional counter.
module tb_shr_out_stage;

  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] d_in;
  logic [DW-1:0] sh_amt_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] d_out;
  logic          zero;
  logic          shift_out_all;
`ifdef SHR_OUT_STATS_EN
  logic [15:0]   xfer_count;
`endif

  shr_out_stage #(.DATAWIDTH(DW)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .d_in          (d_in),
    .sh_amt_in     (sh_amt_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .d_out         (d_out),
    .zero          (zero),
    .shift_out_all (shift_out_all)
`ifdef SHR_OUT_STATS_EN
    ,
    .xfer_count    (xfer_count)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] d;
    logic       z;
    logic       s;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [7:0] sh;
    logic       z;
    logic       s;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] d, input logic [7:0] sh);
    exp_t e;
    e.d = d;
    e.z = (d == 8'h00);
    e.s = (sh >= 8'd8);
    return e;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard: inputs change 1 time unit after the rising edge, so at the falling
  // edge every signal already holds the value the next rising edge will see.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got output 0x%0h, required no output", d_out);
        end else begin
          e = sb_q.pop_front();
          check("sb_d_out", 32'(d_out), 32'(e.d));
          check("sb_zero", 32'(zero), 32'(e.z));
          check("sb_shift_out_all", 32'(shift_out_all), 32'(e.s));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(d_in, sh_amt_in));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[7];
    logic       held;
    logic [7:0] prev_d;

    vecs[0] = '{d: 8'h00, sh: 8'd8,   z: 1'b1, s: 1'b1};
    vecs[1] = '{d: 8'h00, sh: 8'd3,   z: 1'b1, s: 1'b0};
    vecs[2] = '{d: 8'h5A, sh: 8'hFF,  z: 1'b0, s: 1'b1};
    vecs[3] = '{d: 8'h80, sh: 8'd0,   z: 1'b0, s: 1'b0};
    vecs[4] = '{d: 8'h01, sh: 8'd7,   z: 1'b0, s: 1'b0};
    vecs[5] = '{d: 8'h00, sh: 8'd0,   z: 1'b1, s: 1'b0};
    vecs[6] = '{d: 8'hFF, sh: 8'd9,   z: 1'b0, s: 1'b1};

    Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d_in = '0; sh_amt_in = '0;
    repeat (2) step();
    Rst = 1'b0;
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_d_out", 32'(d_out), 32'h00);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_shift_out_all", 32'(shift_out_all), 32'd0);

    // Single entry, consumer always ready.
    in_valid = 1'b1; d_in = 8'h2D; sh_amt_in = 8'd2; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_d_out", 32'(d_out), 32'h2D);
    check("single_zero", 32'(zero), 32'd0);
    check("single_soa", 32'(shift_out_all), 32'd0);
    step();
    check("single_drained", 32'(out_valid), 32'd0);

    // Backpressure: fill main and skid, hold third entry upstream, then stream out.
    out_ready = 1'b0; in_valid = 1'b1; d_in = 8'h11; sh_amt_in = 8'd1;
    step();
    check("bp_ready_after_1", 32'(in_ready), 32'd1);
    d_in = 8'h22;
    step();
    check("bp_ready_after_2", 32'(in_ready), 32'd0);
    d_in = 8'h33;
    step();
    step();
    check("bp_ready_held", 32'(in_ready), 32'd0);
    check("bp_hold_d_out", 32'(d_out), 32'h11);
    out_ready = 1'b1;
    step();
    check("bp_stream_d1", 32'(d_out), 32'h22);
    check("bp_stream_v1", 32'(out_valid), 32'd1);
    check("bp_stream_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_stream_d2", 32'(d_out), 32'h33);
    check("bp_stream_v2", 32'(out_valid), 32'd1);
    step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Flag vectors streamed back to back; main always shows the latest accept.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; d_in = vecs[i].d; sh_amt_in = vecs[i].sh;
      step();
      check($sformatf("vec%0d_d_out", i), 32'(d_out), 32'(vecs[i].d));
      check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      check($sformatf("vec%0d_soa", i), 32'(shift_out_all), 32'(vecs[i].s));
      check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();

    // Random traffic on both sides; scoreboard checks order, stall check checks stability.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      d_in      = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      sh_amt_in = 8'($urandom_range(0, 15));
      held      = out_valid && !out_ready;
      prev_d    = d_out;
      step();
      if (held) check("rand_stall_stable", 32'(d_out), 32'(prev_d));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
    step();
    check("rand_drain_empty", 32'(sb_q.size()), 32'd0);
    check("rand_drain_valid", 32'(out_valid), 32'd0);

    // Reset while full: buffered entries must never appear.
    out_ready = 1'b0; in_valid = 1'b1; d_in = 8'hAA; sh_amt_in = 8'd1;
    step();
    d_in = 8'hBB;
    step();
    in_valid = 1'b0;
    check("mid_full_ready", 32'(in_ready), 32'd0);
    check("mid_full_d_out", 32'(d_out), 32'hAA);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_d_out", 32'(d_out), 32'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_no_emit", 32'(out_valid), 32'd0);
    end

`ifdef SHR_OUT_STATS_EN
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("cnt_after_rst", 32'(xfer_count), 32'd0);
    out_ready = 1'b1; in_valid = 1'b1; sh_amt_in = 8'd0;
    for (int i = 0; i < 70000; i++) begin
      d_in = 8'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    check("cnt_wrap", 32'(xfer_count), 32'd4464);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("cnt_rst", 32'(xfer_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shr_out_stage.md
Name: shr_out_stage

Overview:
- Registered, elastic output stage directly downstream of the combinational right-shifter in the datapath component library.
- Captures the shifter result `d` together with the shift amount that produced it, and presents them to the next consumer over a valid/ready handshake.
- Uses a 2-entry skid buffer so that `in_ready` is a registered signal and full throughput is sustained.
- Adds two status flags per result: `zero` and `shift_out_all`.

Parameters:
- DATAWIDTH, 2, width of the shifter result and of the shift amount (matches the shifter's DATAWIDTH).

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a result on d_in/sh_amt_in this cycle.
- in_ready  output  1  stage can accept; registered.
- d_in  input  DATAWIDTH  shifter result (a >> sh_amt).
- sh_amt_in  input  DATAWIDTH  shift amount that produced d_in.
- out_valid  output  1  d_out and the flags hold a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- d_out  output  DATAWIDTH  buffered result.
- zero  output  1  d_out == 0.
- shift_out_all  output  1  buffered sh_amt >= DATAWIDTH (every bit shifted out); compare at full width, no truncation.

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high.
- Transfers:
  - Input transfer when in_valid && in_ready at the rising edge.
  - Output transfer when out_valid && out_ready at the rising edge.
- Storage: main register (drives the outputs) and skid register. Each entry holds {d, zero, shift_out_all}. Both flags are computed at capture from d_in and sh_amt_in.
- States:
  - EMPTY: main and skid empty.
  - HALF: main full, skid empty.
  - FULL: both full.
- Transitions (in = input transfer, out = output transfer):
  - EMPTY + in -> HALF; main <= input.
  - HALF + in, no out -> FULL; skid <= input.
  - HALF + out, no in -> EMPTY.
  - HALF + in + out -> HALF; main <= input.
  - FULL + out -> HALF; main <= skid. No input is possible in FULL because in_ready = 0.
  - Any other combination -> hold state and contents.
- Registered outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (next state != FULL).
- Latency: an entry accepted at edge N is visible on d_out with out_valid = 1 after edge N when the stage was EMPTY. Throughput is 1 entry per cycle when out_ready is held high.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Stability: while out_valid = 1 and out_ready = 0, d_out, zero and shift_out_all hold stable.
- Reset values after a Rst edge:
  - state = EMPTY.
  - out_valid = 0.
  - d_out = 0, zero = 0, shift_out_all = 0.
  - in_ready = 1.
  - Skid contents = 0.
- Reset rules:
  - While Rst is high, no transfer is counted on either side.
  - Reset mid-operation discards all buffered entries.
- Boundary conditions:
  - out_ready is ignored when out_valid = 0.
  - in_valid is ignored when in_ready = 0.
  - sh_amt_in = 0 -> shift_out_all = 0.

Optional Feature:
- Macro: SHR_OUT_STATS_EN.
- When defined:
  - Extra output port xfer_count, 16 bits.
  - Incremented on every output transfer; wraps 0xFFFF -> 0x0000.
  - Reset to 0 by Rst.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan (DATAWIDTH = 8):
- Reset, then idle -> out_valid = 0, in_ready = 1, d_out = 0x00, zero = 0, shift_out_all = 0.
- Single entry: in_valid = 1, d_in = 0x2D, sh_amt_in = 2, out_ready = 1.
  - Next cycle: out_valid = 1, d_out = 0x2D, zero = 0, shift_out_all = 0.
  - Cycle after that: out_valid = 0.
- Backpressure: out_ready = 0; push 0x11, 0x22, 0x33 back-to-back.
  - in_ready drops to 0 after the second accept; 0x33 is held upstream.
  - Raise out_ready: outputs appear in order 0x11, 0x22, 0x33, with no gaps once streaming.
- Flags:
  - d_in = 0x00, sh_amt_in = 8 -> zero = 1, shift_out_all = 1.
  - d_in = 0x00, sh_amt_in = 3 -> zero = 1, shift_out_all = 0.
  - sh_amt_in = 0xFF -> shift_out_all = 1.
- Reset mid-operation: stage FULL (0xAA, 0xBB), assert Rst for 1 cycle -> out_valid = 0, in_ready = 1, and 0xAA/0xBB are never emitted.
- With SHR_OUT_STATS_EN:
  - 70000 streamed transfers -> xfer_count = 70000 mod 65536 = 4464.
  - Rst -> xfer_count = 0.
